// File: rtl/cs_window_seq_pkg.sv
// Shared types and default sizes for the windowed-average sequencer and the cs_core engine.
package cs_pkg;

  localparam int CS_WIN = 9;
  localparam int CS_DW  = 8;
  localparam int CS_YW  = 10;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_FILL,
    CS_RUN,
    CS_FLUSH
  } cs_seq_state_t;

endpackage

// File: rtl/cs_window_seq_if.sv
// Sample-in and result-out streams of the window sequencer.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
// a producer holds valid and data stable until that edge, and ready may depend on valid.
interface cs_window_seq_if #(
  parameter int DW = cs_pkg::CS_DW,
  parameter int YW = cs_pkg::CS_YW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [YW-1:0] out_data;

  // slave: the sequencer's view (consumes samples, produces results)
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // master: the environment's view
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/cs_window_seq_outbuf.sv
// One-entry result holding register: loads on cap, drops valid once the consumer takes it.
module cs_seq_outbuf #(
  parameter int YW = cs_pkg::CS_YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap,
  input  logic [YW-1:0] cap_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [YW-1:0] out_data
);

  logic          out_valid_d, out_valid_q;
  logic [YW-1:0] out_data_d,  out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (cap) begin
      out_valid_d = 1'b1;
      out_data_d  = cap_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/cs_window_seq.sv
// Sequencer for the cs_core windowed-average engine: fill tracking, result capture, zero flush.
// Optional statistics counters are built when CS_STATS_EN is defined.
module cs_window_seq
  import cs_pkg::*;
#(
  parameter int WIN = CS_WIN,
  parameter int DW  = CS_DW,
  parameter int YW  = CS_YW,
  localparam int CW = $clog2(WIN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  cs_window_seq_if.slave  io,
  input  logic            flush_req,
  output logic            eng_shift,
  output logic [DW-1:0]   eng_x,
  input  logic [YW-1:0]   eng_y,
  output logic [CW-1:0]   fill_cnt,
  output logic            busy,
  output logic [15:0]     res_cnt,
  output logic [15:0]     stall_cnt,
  output cs_seq_state_t   dbg_state
);

  cs_seq_state_t state_d, state_q;
  logic [CW-1:0] fill_d, fill_q;
  logic [CW-1:0] flush_cnt_d, flush_cnt_q;
  logic          pend_d, pend_q;

  logic out_valid;
  logic stall;
  logic in_ready;
  logic in_fire;
  logic flush_entry;
  logic cap;

  assign out_valid = io.out_valid;

  always_comb begin
    stall       = pend_q & out_valid & ~io.out_ready;
    in_ready    = ~flush_req & (state_q != CS_FLUSH) & ~stall;
    in_fire     = io.in_valid & in_ready;
    flush_entry = flush_req & (state_q != CS_FLUSH);
    cap         = pend_q & (~out_valid | io.out_ready);
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    flush_cnt_d = flush_cnt_q;
    // eng_y is only meaningful after the sample that completes or advances a full window
    pend_d      = (in_fire & ((state_q == CS_RUN) | (fill_q == CW'(WIN - 1)))) | stall;

    if (in_fire && (fill_q != CW'(WIN))) begin
      fill_d = fill_q + 1'b1;
    end

    if (flush_entry) begin
      state_d     = CS_FLUSH;
      flush_cnt_d = '0;
      pend_d      = 1'b0;
    end else begin
      case (state_q)
        CS_IDLE: begin
          if (in_fire) state_d = (fill_q == CW'(WIN - 1)) ? CS_RUN : CS_FILL;
        end
        CS_FILL: begin
          if (in_fire && (fill_q == CW'(WIN - 1))) state_d = CS_RUN;
        end
        CS_RUN: begin
          state_d = CS_RUN;
        end
        CS_FLUSH: begin
          if (flush_cnt_q == CW'(WIN - 1)) begin
            state_d     = CS_IDLE;
            flush_cnt_d = '0;
            fill_d      = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        default: state_d = CS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CS_IDLE;
      fill_q      <= '0;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
    end
  end

  cs_seq_outbuf #(.YW(YW)) u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .cap       (cap),
    .cap_data  (eng_y),
    .out_ready (io.out_ready),
    .out_valid (io.out_valid),
    .out_data  (io.out_data)
  );

  // Flush pushes zeros through every tap so a restart begins from an empty window
  assign eng_shift   = (state_q == CS_FLUSH) | in_fire;
  assign eng_x       = ((state_q != CS_FLUSH) && in_fire) ? io.in_data : '0;
  assign io.in_ready = in_ready;
  assign fill_cnt    = fill_q;
  assign busy        = (state_q != CS_IDLE) | pend_q | out_valid;
  assign dbg_state   = state_q;

`ifdef CS_STATS_EN
  logic [15:0] res_cnt_d,   res_cnt_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    res_cnt_d   = res_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid && io.out_ready) res_cnt_d = res_cnt_q + 16'd1;
    if (out_valid && !io.out_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      res_cnt_q   <= res_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign res_cnt   = res_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign res_cnt   = 16'd0;
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cs_window_seq.sv
// Bench for cs_window_seq with a behavioural 9-tap engine (sum of taps >> 2) attached.
module tb_cs_window_seq;
  import cs_pkg::*;

  localparam int WIN = 9;
  localparam int DW  = 8;
  localparam int YW  = 10;
  localparam int CW  = $clog2(WIN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cs_window_seq_if #(.DW(DW), .YW(YW)) bus ();
  logic          flush_req;
  logic          eng_shift;
  logic [DW-1:0] eng_x;
  logic [YW-1:0] eng_y;
  logic [CW-1:0] fill_cnt;
  logic          busy;
  logic [15:0]   res_cnt;
  logic [15:0]   stall_cnt;
  cs_seq_state_t dbg_state;

  cs_window_seq #(.WIN(WIN), .DW(DW), .YW(YW)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (bus),
    .flush_req (flush_req),
    .eng_shift (eng_shift),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .fill_cnt  (fill_cnt),
    .busy      (busy),
    .res_cnt   (res_cnt),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // Engine model: newest sample at taps[0], result = sum >> 2
  logic [DW-1:0] taps [WIN];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) taps[i] <= '0;
    end else if (eng_shift) begin
      for (int i = WIN - 1; i > 0; i--) taps[i] <= taps[i-1];
      taps[0] <= eng_x;
    end
  end
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < WIN; i++) s += int'(taps[i]);
    eng_y = YW'(s >> 2);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: results expected on out_fire, in order
  logic [YW-1:0] exp_q[$];
  logic          sb_en = 1'b0;
  always @(negedge clk) begin
    if (sb_en && reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb unexpected result", int'(bus.out_data), -1);
      end else begin
        chk("sb result", int'(bus.out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int iv, d, fr, ordy;
    int rdy, ov, od, fill, shift, engx, busy;
  } vec_t;
  vec_t tab[$];

  task automatic add(input int iv, input int d, input int fr, input int ordy,
                     input int rdy, input int ov, input int od, input int fill,
                     input int shift, input int engx, input int bsy);
    vec_t v;
    v.iv = iv; v.d = d; v.fr = fr; v.ordy = ordy;
    v.rdy = rdy; v.ov = ov; v.od = od; v.fill = fill;
    v.shift = shift; v.engx = engx; v.busy = bsy;
    tab.push_back(v);
  endtask

  // Each row: drive just after a rising edge, check at the following falling edge (-1 = don't care)
  task automatic run_table(input string tag);
    foreach (tab[i]) begin
      @(posedge clk);
      #1;
      bus.in_valid  = tab[i].iv[0];
      bus.in_data   = DW'(tab[i].d);
      flush_req     = tab[i].fr[0];
      bus.out_ready = tab[i].ordy[0];
      @(negedge clk);
      if (tab[i].rdy   >= 0) chk($sformatf("%s[%0d] in_ready",  tag, i), int'(bus.in_ready),  tab[i].rdy);
      if (tab[i].ov    >= 0) chk($sformatf("%s[%0d] out_valid", tag, i), int'(bus.out_valid), tab[i].ov);
      if (tab[i].od    >= 0) chk($sformatf("%s[%0d] out_data",  tag, i), int'(bus.out_data),  tab[i].od);
      if (tab[i].fill  >= 0) chk($sformatf("%s[%0d] fill_cnt",  tag, i), int'(fill_cnt),      tab[i].fill);
      if (tab[i].shift >= 0) chk($sformatf("%s[%0d] eng_shift", tag, i), int'(eng_shift),     tab[i].shift);
      if (tab[i].engx  >= 0) chk($sformatf("%s[%0d] eng_x",     tag, i), int'(eng_x),         tab[i].engx);
      if (tab[i].busy  >= 0) chk($sformatf("%s[%0d] busy",      tag, i), int'(busy),          tab[i].busy);
    end
    tab.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    flush_req     = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " out_data"},  int'(bus.out_data),  0);
    chk({tag, " in_ready"},  int'(bus.in_ready),  1);
    chk({tag, " fill_cnt"},  int'(fill_cnt),      0);
    chk({tag, " busy"},      int'(busy),          0);
    chk({tag, " eng_shift"}, int'(eng_shift),     0);
    chk({tag, " eng_x"},     int'(eng_x),         0);
    chk({tag, " state"},     int'(dbg_state),     int'(CS_IDLE));
  endtask

  initial begin
    // ---- reset values ----
    do_reset();
    check_reset_state("reset");
    chk("reset res_cnt",   int'(res_cnt),   0);
    chk("reset stall_cnt", int'(stall_cnt), 0);

    // ---- fill, steady stream, 4-cycle output stall ----
    for (int c = 0; c < 9; c++) add(1, 10, 0, 1, 1, 0, -1, c, 1, 10, (c == 0) ? 0 : 1);
    add(1, 10, 0, 1, 1, 0, -1, 9, 1, 10, 1);
    add(1, 50, 0, 1, 1, 1, 22, 9, 1, 50, 1);
    for (int c = 0; c < 4; c++) add(1, 30, 0, 0, 0, 1, 22, 9, 0, -1, 1);
    add(1, 30, 0, 1, 1, 1, 22, 9, 1, 30, 1);
    add(1, 40, 0, 1, 1, 1, 32, 9, 1, 40, 1);
    add(0, 0,  0, 1, 1, 1, 37, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 1, 45, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 0, -1, 9, 0, -1, 1);
    add(1, 10, 0, 1, 1, 0, -1, 9, 1, 10, 1);
    add(0, 0,  0, 0, 1, 0, -1, 9, 0, -1, 1);
    exp_q = '{10'd22, 10'd22, 10'd32, 10'd37, 10'd45};
    sb_en = 1'b1;
    run_table("main");
    sb_en = 1'b0;
    chk("sb leftover results", exp_q.size(), 0);

    // ---- asynchronous reset while a result is held ----
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("pre-reset out_valid", int'(bus.out_valid), 1);
    chk("pre-reset out_data",  int'(bus.out_data),  45);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midrun reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) add(1, 10, 0, 1, 1, 0, -1, c, 1, 10, -1);
    add(0, 0, 0, 1, 1, 0, -1, 8, 0, -1, 1);
    add(0, 0, 0, 1, 1, 0, -1, 8, 0, -1, 1);
    run_table("post_reset");

    // ---- flush after 5 samples; flush_req beats in_valid ----
    do_reset();
    for (int c = 0; c < 5; c++) add(1, 10, 0, 1, 1, 0, -1, c, 1, 10, (c == 0) ? 0 : 1);
    add(1, 99, 1, 1, 0, 0, -1, 5, 0, -1, 1);
    for (int c = 0; c < 9; c++) add(1, 99, (c < 2) ? 1 : 0, 1, 0, 0, -1, -1, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, -1, 0, 0, -1, 0);
    for (int c = 0; c < 8; c++) add(1, 10, 0, 1, 1, 0, -1, c, 1, 10, -1);
    add(1, 10, 0, 1, 1, 0, -1, 8, 1, 10, 1);
    add(0, 0,  0, 1, 1, 0, -1, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 1, 22, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 0, -1, 9, 0, -1, 1);
    run_table("flush");

    // ---- statistics: 3 results, 2 stalled cycles ----
    do_reset();
    for (int c = 0; c < 9; c++) add(1, 10, 0, 1, 1, 0, -1, c, 1, 10, -1);
    add(1, 10, 0, 1, 1, 0, -1, 9, 1, 10, 1);
    add(1, 10, 0, 1, 1, 1, 22, 9, 1, 10, 1);
    add(0, 0,  0, 0, 0, 1, 22, 9, 0, -1, 1);
    add(0, 0,  0, 0, 0, 1, 22, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 1, 22, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 1, 22, 9, 0, -1, 1);
    add(0, 0,  0, 1, 1, 0, -1, 9, 0, -1, 1);
    run_table("stats");
`ifdef CS_STATS_EN
    chk("stats res_cnt",   int'(res_cnt),   3);
    chk("stats stall_cnt", int'(stall_cnt), 2);
`else
    chk("stats res_cnt",   int'(res_cnt),   0);
    chk("stats stall_cnt", int'(stall_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
